// File: rtl/icache_responder.sv
// icache_responder
//   Instruction-cache responder sitting between fetch1 (request stage) and
//   fetch2 (consumer). A request presented in cycle N is latched into the
//   lookup-stage register. The set is read on the same edge. In cycle N+1 the
//   tags are compared and one instruction word is returned. A miss or an
//   uncached access raises icache_busy and runs a burst read on the memory port.
//
//   Cache shape: 2-way set-associative, 16B lines, 1-bit LRU per set, VIPT
//   (set from icache_idx[11:4], tag from icache_pa[31:12]).
//
//   Op encoding: IC_NOP=0, IC_R=1, IC_IDX_INV=2, IC_HIT_INV=3.
//
//   Optional feature macro: ICACHE_CACOP_EN
//     When this macro is defined, IC_IDX_INV and IC_HIT_INV execute in the
//     lookup stage.
//     When it is undefined, both ops are ignored like IC_NOP.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   icache_idx/op/pa/is_cached  fetch1 request
//   icache_busy                 request this cycle not accepted
//   stall, flush                fetch2 back-pressure / redirect kill
//   rdata, rdata_valid          returned instruction word
//   mem_rd_*                    burst read port for refills
//
// FSM states
//   state    | meaning
//   S_IDLE   | lookup stage: tag compare, hit return, miss detection
//   S_MISS   | read request held on memory port until mem_rd_rdy
//   S_REFILL | collecting beats into the line buffer
//   S_DONE   | returning the refilled word, waiting for stall to drop

module icache_responder #(
  parameter int OFFSET_W = 4,
  parameter int INDEX_W  = 8,
  parameter int TAG_W    = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] icache_idx,
  input  logic [2:0]  icache_op,
  input  logic [31:0] icache_pa,
  input  logic        icache_is_cached,
  output logic        icache_busy,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  output logic [1:0]  mem_rd_len,
  input  logic        mem_rd_rdy,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_last
);

  localparam int WSEL_W = OFFSET_W - 2;
  localparam int WORDS  = 1 << WSEL_W;
  localparam int SETS   = 1 << INDEX_W;

  localparam logic [2:0] IC_NOP = 3'd0;
  localparam logic [2:0] IC_R   = 3'd1;
`ifdef ICACHE_CACOP_EN
  localparam logic [2:0] IC_IDX_INV = 3'd2;
  localparam logic [2:0] IC_HIT_INV = 3'd3;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MISS   = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0] state;

  // lookup-stage register
  logic               stage_vld;
  logic [2:0]         stage_op;
  logic [31:0]        stage_pa;
  logic [INDEX_W-1:0] stage_set;
  logic               stage_cached;

  // tag/data are read on the accept edge. Valid and LRU are flops that are
  // read directly with the stage set. An invalidate in the same cycle as a
  // new accept to the same set is therefore never seen stale.
  logic [TAG_W-1:0] tag_arr  [2][SETS];
  logic [31:0]      data_arr [2][SETS][WORDS];
  logic [1:0]       valid_arr [SETS];
  logic [SETS-1:0]  lru_arr;      // way to replace next
  logic [TAG_W-1:0] rd_tag  [2];
  logic [31:0]      rd_line [2][WORDS];

  logic [31:0]       line_buf [WORDS];
  logic [WSEL_W-1:0] beat_idx;
  logic              victim;
  logic              flush_seen;

  logic [INDEX_W-1:0] set_in;
  logic [TAG_W-1:0]   stage_tag;
  logic [WSEL_W-1:0]  stage_word;
  logic [1:0]         way_hit;
  logic               hit_way;
  logic               is_rd;
  logic               lookup_hit;
  logic               lookup_miss;
  logic               op_ok;
  logic               accept;
  logic               fill_we;
  logic               unused_ok;

  assign set_in     = icache_idx[11:OFFSET_W];
  assign unused_ok  = ^icache_idx[OFFSET_W-1:0];
  assign stage_tag  = stage_pa[31:32-TAG_W];
  assign stage_word = stage_pa[OFFSET_W-1:2];

  assign way_hit[0] = valid_arr[stage_set][0] && (rd_tag[0] == stage_tag);
  assign way_hit[1] = valid_arr[stage_set][1] && (rd_tag[1] == stage_tag);
  assign hit_way    = way_hit[1];

  assign is_rd       = stage_vld && (stage_op == IC_R);
  assign lookup_hit  = is_rd && stage_cached && (|way_hit);
  assign lookup_miss = is_rd && !(stage_cached && (|way_hit));

`ifdef ICACHE_CACOP_EN
  assign op_ok = (icache_op == IC_R) || (icache_op == IC_IDX_INV) ||
                 (icache_op == IC_HIT_INV);
`else
  assign op_ok = (icache_op == IC_R);
`endif

  // A flush in the lookup cycle suppresses the miss. This lets the
  // redirected request be accepted in the same cycle.
  assign icache_busy = ((state == S_IDLE) && lookup_miss && !flush) ||
                       (state == S_MISS) || (state == S_REFILL);
  assign accept      = op_ok && !icache_busy && !stall;

  assign fill_we = (state == S_REFILL) && mem_rd_valid && mem_rd_last && stage_cached;

  assign mem_rd_req  = (state == S_MISS);
  assign mem_rd_addr = stage_cached ? {stage_pa[31:OFFSET_W], {OFFSET_W{1'b0}}} : stage_pa;
  assign mem_rd_len  = stage_cached ? 2'(WORDS - 1) : 2'd0;

  always_comb begin
    rdata       = '0;
    rdata_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (lookup_hit) begin
          rdata       = rd_line[hit_way][stage_word];
          rdata_valid = 1'b1;
        end
      end
      S_DONE: begin
        // an uncached burst is a single beat held in word 0
        rdata       = stage_cached ? line_buf[stage_word] : line_buf[0];
        rdata_valid = !flush_seen;
      end
      default: ;
    endcase
  end

  // Data/tag storage and the line buffer are not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int w = 0; w < 2; w++) begin
        rd_tag[w] <= tag_arr[w][set_in];
        for (int k = 0; k < WORDS; k++) rd_line[w][k] <= data_arr[w][set_in][k];
      end
    end
    if ((state == S_REFILL) && mem_rd_valid) line_buf[beat_idx] <= mem_rd_data;
    if (fill_we && rst_n) begin
      tag_arr[victim][stage_set] <= stage_tag;
      for (int k = 0; k < WORDS; k++)
        data_arr[victim][stage_set][k] <= (beat_idx == WSEL_W'(k)) ? mem_rd_data : line_buf[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      stage_vld    <= 1'b0;
      stage_op     <= IC_NOP;
      stage_pa     <= '0;
      stage_set    <= '0;
      stage_cached <= 1'b0;
      beat_idx     <= '0;
      victim       <= 1'b0;
      flush_seen   <= 1'b0;
      lru_arr      <= '0;
      for (int s = 0; s < SETS; s++) valid_arr[s] <= 2'b00;
    end else begin
      if (accept) begin
        stage_vld    <= 1'b1;
        stage_op     <= icache_op;
        stage_pa     <= icache_pa;
        stage_set    <= set_in;
        stage_cached <= icache_is_cached;
      end else if ((state == S_IDLE) && (flush || (!stall && !icache_busy))) begin
        stage_vld <= 1'b0;
      end else if ((state == S_DONE) && !stall) begin
        stage_vld <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (lookup_hit) lru_arr[stage_set] <= ~hit_way;
          if (lookup_miss && !flush) begin
            state      <= S_MISS;
            flush_seen <= 1'b0;
            // invalid ways are filled before the LRU way is evicted
            if (!valid_arr[stage_set][0])      victim <= 1'b0;
            else if (!valid_arr[stage_set][1]) victim <= 1'b1;
            else                               victim <= lru_arr[stage_set];
          end
`ifdef ICACHE_CACOP_EN
          if (stage_vld && !flush) begin
            if (stage_op == IC_IDX_INV)
              valid_arr[stage_set][stage_pa[0]] <= 1'b0;
            else if ((stage_op == IC_HIT_INV) && (|way_hit))
              valid_arr[stage_set][hit_way] <= 1'b0;
          end
`endif
        end
        S_MISS: begin
          if (flush) flush_seen <= 1'b1;
          if (mem_rd_rdy) begin
            state    <= S_REFILL;
            beat_idx <= '0;
          end
        end
        S_REFILL: begin
          if (flush) flush_seen <= 1'b1;
          if (mem_rd_valid) begin
            beat_idx <= beat_idx + 1'b1;
            if (mem_rd_last) begin
              state <= S_DONE;
              if (stage_cached) begin
                valid_arr[stage_set][victim] <= 1'b1;
                lru_arr[stage_set]           <= ~victim;
              end
            end
          end
        end
        S_DONE: begin
          if (!stall) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
